// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   EX/MEM pipeline register, data-memory access and MEM/WB pipeline register.
//   Loads and stores use a req/ready handshake plus a separate rvalid return.
//   While an access is outstanding, upstream stages are stalled.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   valid_ex .. MemtoReg_ex       EX-stage instruction fields (inputs)
//   mem_stall                     hold PC, IF/ID, ID/EX and EX inputs this cycle
//   dmem_req/we/addr/wdata        data-memory request (outputs)
//   dmem_ready/rvalid/rdata       data-memory handshake and return (inputs)
//   ALUResult_mem/rdAddr_mem/RegWrite_mem      EX/MEM forward path
//   RegWriteData_wb/rdAddr_wb/RegWrite_wb      MEM/WB forward and write-back
//   mem_err                       sticky: watchdog forced completion
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_ex,
    input  logic [31:0] ALUResult_ex,
    input  logic [31:0] MemWriteData_ex,
    input  logic [4:0]  rdAddr_ex,
    input  logic        RegWrite_ex,
    input  logic        MemRead_ex,
    input  logic        MemWrite_ex,
    input  logic        MemtoReg_ex,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ALUResult_mem,
    output logic [4:0]  rdAddr_mem,
    output logic        RegWrite_mem,
    output logic [31:0] RegWriteData_wb,
    output logic [4:0]  rdAddr_wb,
    output logic        RegWrite_wb,
    output logic        mem_err
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_wd_cnt;
    logic          r_mem_err;

    // EX/MEM register; control bits are pre-qualified with valid
    logic          r_valid_mem;
    logic          r_regwrite_mem;
    logic          r_memread_mem;
    logic          r_memwrite_mem;
    logic          r_memtoreg_mem;
    logic [31:0]   r_alu_mem;
    logic [31:0]   r_wdata_mem;
    logic [4:0]    r_rd_mem;

    // MEM/WB register
    logic [31:0]   r_wb_data;
    logic [4:0]    r_rd_wb;
    logic          r_regwrite_wb;

    logic          w_memop;
    logic          w_wd_fire;
    logic          w_store_done;
    logic          w_load_accept;
    logic          w_load_done;
    logic          w_done;
    logic          w_stall;
    logic [31:0]   w_load_data;
    logic [31:0]   w_wb_data;

    assign w_memop       = r_valid_mem & (r_memread_mem | r_memwrite_mem);
    // Watchdog fires once the counter has seen TIMEOUT stall cycles
    assign w_wd_fire     = (TIMEOUT != 0) && w_memop && (r_wd_cnt == CW'(TIMEOUT));
    assign w_store_done  = (r_state == ST_ISSUE) & r_memwrite_mem & dmem_ready;
    assign w_load_accept = (r_state == ST_ISSUE) & r_memread_mem & dmem_ready;
    assign w_load_done   = (r_state == ST_WAIT) & dmem_rvalid;
    assign w_done        = w_memop & (w_wd_fire | w_store_done | w_load_done);
    assign w_stall       = w_memop & ~w_done;
    assign w_load_data   = w_wd_fire ? '0 : dmem_rdata;
    assign w_wb_data     = r_memtoreg_mem ? w_load_data : r_alu_mem;

    // Built from registered state only, so it falls as soon as reset clears them
    assign dmem_req      = w_memop & (r_state == ST_ISSUE) & ~w_wd_fire;
    assign dmem_we       = r_memwrite_mem;
    assign dmem_addr     = r_alu_mem;
    assign dmem_wdata    = r_wdata_mem;
    assign mem_stall     = w_stall;
    assign ALUResult_mem = r_alu_mem;
    assign rdAddr_mem    = r_rd_mem;
    assign RegWrite_mem  = r_regwrite_mem;
    assign RegWriteData_wb = r_wb_data;
    assign rdAddr_wb     = r_rd_wb;
    assign RegWrite_wb   = r_regwrite_wb;
    assign mem_err       = r_mem_err;

    // Pipeline registers: both stages advance together or both hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_mem    <= 1'b0;
            r_regwrite_mem <= 1'b0;
            r_memread_mem  <= 1'b0;
            r_memwrite_mem <= 1'b0;
            r_memtoreg_mem <= 1'b0;
            r_alu_mem      <= '0;
            r_wdata_mem    <= '0;
            r_rd_mem       <= '0;
            r_wb_data      <= '0;
            r_rd_wb        <= '0;
            r_regwrite_wb  <= 1'b0;
        end else if (!w_stall) begin
            r_valid_mem    <= valid_ex;
            r_regwrite_mem <= valid_ex & RegWrite_ex;
            r_memread_mem  <= valid_ex & MemRead_ex;
            r_memwrite_mem <= valid_ex & MemWrite_ex;
            r_memtoreg_mem <= valid_ex & MemtoReg_ex;
            r_alu_mem      <= ALUResult_ex;
            r_wdata_mem    <= MemWriteData_ex;
            r_rd_mem       <= rdAddr_ex;
            r_wb_data      <= w_wb_data;
            r_rd_wb        <= r_rd_mem;
            r_regwrite_wb  <= r_regwrite_mem;
        end
    end

    // Access FSM and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ISSUE;
            r_wd_cnt  <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_done) begin
                r_wd_cnt <= '0;
            end else if (w_stall) begin
                r_wd_cnt <= r_wd_cnt + CW'(1);
            end

            if (w_wd_fire) begin
                r_mem_err <= 1'b1;
                r_state   <= ST_ISSUE;
            end else begin
                case (r_state)
                    ST_ISSUE: if (w_load_accept) r_state <= ST_WAIT;
                    ST_WAIT:  if (dmem_rvalid)   r_state <= ST_ISSUE;
                    default:                     r_state <= ST_ISSUE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
    logic [31:0] ALUResult_ex, MemWriteData_ex;
    logic [4:0]  rdAddr_ex;

    logic        mem_stall, dmem_req, dmem_we, dmem_ready, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] ALUResult_mem, RegWriteData_wb;
    logic [4:0]  rdAddr_mem, rdAddr_wb;
    logic        RegWrite_mem, RegWrite_wb, mem_err;

    logic        wd_mem_stall, wd_dmem_req, wd_dmem_we;
    logic [31:0] wd_dmem_addr, wd_dmem_wdata, wd_ALUResult_mem, wd_RegWriteData_wb;
    logic [4:0]  wd_rdAddr_mem, wd_rdAddr_wb;
    logic        wd_RegWrite_mem, wd_RegWrite_wb, wd_mem_err;
    logic        wd_ready, wd_rvalid;
    logic [31:0] wd_rdata;

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT(255)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .ALUResult_ex(ALUResult_ex),
        .MemWriteData_ex(MemWriteData_ex), .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex),
        .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
        .RegWrite_mem(RegWrite_mem), .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb),
        .RegWrite_wb(RegWrite_wb), .mem_err(mem_err)
    );

    // Second instance with a short watchdog and a memory that never answers
    mem_wb_stage #(.TIMEOUT(4)) u_wd (
        .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .ALUResult_ex(ALUResult_ex),
        .MemWriteData_ex(MemWriteData_ex), .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex),
        .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .mem_stall(wd_mem_stall), .dmem_req(wd_dmem_req), .dmem_we(wd_dmem_we),
        .dmem_addr(wd_dmem_addr), .dmem_wdata(wd_dmem_wdata), .dmem_ready(wd_ready),
        .dmem_rvalid(wd_rvalid), .dmem_rdata(wd_rdata), .ALUResult_mem(wd_ALUResult_mem),
        .rdAddr_mem(wd_rdAddr_mem), .RegWrite_mem(wd_RegWrite_mem),
        .RegWriteData_wb(wd_RegWriteData_wb), .rdAddr_wb(wd_rdAddr_wb),
        .RegWrite_wb(wd_RegWrite_wb), .mem_err(wd_mem_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } mreq_t;
    wb_t   wb_q[$];
    mreq_t mem_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: ready after ready_delay waiting cycles, rvalid rvalid_delay cycles after accept
    int          ready_delay = 0;
    int          rvalid_delay = 1;
    int          wait_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] load_rdata = '0;

    initial begin
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hBAD0BAD0;
        forever begin
            @(posedge clk); #2;
            dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hBAD0BAD0;
            if (!rst_n) begin
                wait_cnt = 0; rv_cnt = 0;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1; dmem_rdata = load_rdata;
                end
            end else if (dmem_req) begin
                if (wait_cnt < ready_delay) wait_cnt++;
                else begin
                    dmem_ready = 1'b1; wait_cnt = 0;
                    if (!dmem_we) rv_cnt = rvalid_delay;
                end
            end
        end
    end

    // Write-back monitor: MEM/WB takes a new entry on every edge without stall
    logic mon_adv = 1'b0;
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (mon_adv && RegWrite_wb) begin
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got rd=%0d data=0x%08h, expected no write-back",
                             rdAddr_wb, RegWriteData_wb);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_rd", {27'b0, rdAddr_wb}, {27'b0, e.rd});
                    check("wb_data", RegWriteData_wb, e.data);
                end
            end
            mon_adv = rst_n && !mem_stall;
        end
    end

    // Memory-request monitor: compares each accepted request
    initial begin
        mreq_t m;
        forever begin
            @(negedge clk);
            if (dmem_req && dmem_ready) begin
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: got addr=0x%08h we=%0b, expected no request",
                             dmem_addr, dmem_we);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_we", {31'b0, dmem_we}, {31'b0, m.we});
                    check("mem_addr", dmem_addr, m.addr);
                    check("mem_wdata", dmem_wdata, m.wdata);
                end
            end
        end
    end

    task automatic set_bubble();
        valid_ex = 1'b0; ALUResult_ex = '0; MemWriteData_ex = '0; rdAddr_ex = '0;
        RegWrite_ex = 1'b0; MemRead_ex = 1'b0; MemWrite_ex = 1'b0; MemtoReg_ex = 1'b0;
    endtask

    // Present one instruction in EX until captured; stalls = cycles held by MEM
    task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic m2r, output int stalls);
        valid_ex = v; ALUResult_ex = alu; MemWriteData_ex = wd; rdAddr_ex = rd;
        RegWrite_ex = rw; MemRead_ex = mr; MemWrite_ex = mw; MemtoReg_ex = m2r;
        stalls = 0;
        @(negedge clk);
        while (mem_stall && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (mem_stall) check("issue_stall_bound", {31'b0, mem_stall}, 32'd0);
        if (v && rw) wb_q.push_back('{rd: rd, data: (m2r ? load_rdata : alu)});
        if (v && (mr || mw)) mem_q.push_back('{we: mw, addr: alu, wdata: wd});
        @(posedge clk); #1;
        set_bubble();
    endtask

    initial begin
        int st;
        int n;
        rst_n = 1'b0;
        set_bubble();
        wd_ready = 1'b0; wd_rvalid = 1'b0; wd_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_rw_mem", {31'b0, RegWrite_mem}, 32'd0);
        check("rst_rw_wb", {31'b0, RegWrite_wb}, 32'd0);
        check("rst_wbdata", RegWriteData_wb, 32'd0);
        check("rst_alu_mem", ALUResult_mem, 32'd0);
        check("rst_err", {31'b0, mem_err}, 32'd0);
        check("rst_wd_err", {31'b0, wd_mem_err}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: add x5
        issue(1, 32'h0000_1234, 32'd0, 5'd5, 1, 0, 0, 0, st);
        check("t1_rd_mem", {27'b0, rdAddr_mem}, 32'd5);
        check("t1_rw_mem", {31'b0, RegWrite_mem}, 32'd1);
        check("t1_alu_mem", ALUResult_mem, 32'h0000_1234);

        // 2: sw 0xDEADBEEF -> 0x100, memory ready immediately
        issue(1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 0, 0, 1, 0, st);
        check("t1_stall", st, 32'd0);
        check("t1_rd_wb", {27'b0, rdAddr_wb}, 32'd5);
        check("t1_rw_wb", {31'b0, RegWrite_wb}, 32'd1);
        check("t1_wbdata", RegWriteData_wb, 32'h0000_1234);
        issue(1, 32'h0000_0044, 32'd0, 5'd4, 1, 0, 0, 0, st);
        check("t2_stall", st, 32'd0);
        check("t2_rw_wb", {31'b0, RegWrite_wb}, 32'd0);

        // 3/4: add x3 then lw x7 from 0x40; ready after 2 cycles, rvalid 3 after accept
        issue(1, 32'h0000_0033, 32'd0, 5'd3, 1, 0, 0, 0, st);
        ready_delay = 2; rvalid_delay = 3; load_rdata = 32'hCAFE_0007;
        issue(1, 32'h0000_0040, 32'd0, 5'd7, 1, 1, 0, 1, st);
        n = 0;
        @(negedge clk);
        while (mem_stall && n < 50) begin
            n++;
            check("t4_rw_wb_held", {31'b0, RegWrite_wb}, 32'd1);
            check("t4_rd_wb_held", {27'b0, rdAddr_wb}, 32'd3);
            check("t4_wbdata_held", RegWriteData_wb, 32'h0000_0033);
            check("t3_rd_mem_held", {27'b0, rdAddr_mem}, 32'd7);
            check("t3_addr_held", dmem_addr, 32'h0000_0040);
            @(negedge clk);
        end
        check("t3_stall_cycles", n, 32'd5);
        @(posedge clk); #1;
        check("t3_rd_wb", {27'b0, rdAddr_wb}, 32'd7);
        check("t3_wbdata", RegWriteData_wb, 32'hCAFE_0007);
        issue(0, 0, 0, 0, 0, 0, 0, 0, st);
        issue(0, 0, 0, 0, 0, 0, 0, 0, st);
        check("drain_wb_q", wb_q.size(), 32'd0);
        check("drain_mem_q", mem_q.size(), 32'd0);

        // 6: reset while the load waits for rvalid
        ready_delay = 0; rvalid_delay = 3; load_rdata = 32'h1010_1010;
        issue(1, 32'h0000_0080, 32'd0, 5'd10, 1, 1, 0, 1, st);
        @(posedge clk); #3;
        check("t6_wait_stall", {31'b0, mem_stall}, 32'd1);
        check("t6_wait_req", {31'b0, dmem_req}, 32'd0);
        rst_n = 1'b0;
        wb_q.delete();
        #1;
        check("t6_rst_stall", {31'b0, mem_stall}, 32'd0);
        check("t6_rst_req", {31'b0, dmem_req}, 32'd0);
        check("t6_rst_rw_mem", {31'b0, RegWrite_mem}, 32'd0);
        check("t6_rst_rd_mem", {27'b0, rdAddr_mem}, 32'd0);
        check("t6_rst_alu_mem", ALUResult_mem, 32'd0);
        check("t6_rst_rw_wb", {31'b0, RegWrite_wb}, 32'd0);
        check("t6_rst_wd_err", {31'b0, wd_mem_err}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 32'h0000_1111, 32'd0, 5'd11, 1, 0, 0, 0, st);
        check("t6_post_stall", st, 32'd0);
        check("t6_post_rd_mem", {27'b0, rdAddr_mem}, 32'd11);
        issue(0, 0, 0, 0, 0, 0, 0, 0, st);
        check("t6_post_rd_wb", {27'b0, rdAddr_wb}, 32'd11);
        check("t6_post_wbdata", RegWriteData_wb, 32'h0000_1111);

        // 5: watchdog on the TIMEOUT=4 instance (main instance completes normally)
        ready_delay = 0; rvalid_delay = 1; load_rdata = 32'h0000_9999;
        issue(1, 32'h0000_0200, 32'd0, 5'd9, 1, 1, 0, 1, st);
        n = 0;
        @(negedge clk);
        while (wd_mem_stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t5_stall_cycles", n, 32'd4);
        check("t5_err_before", {31'b0, wd_mem_err}, 32'd0);
        @(posedge clk); #1;
        check("t5_err", {31'b0, wd_mem_err}, 32'd1);
        check("t5_rw_wb", {31'b0, wd_RegWrite_wb}, 32'd1);
        check("t5_rd_wb", {27'b0, wd_rdAddr_wb}, 32'd9);
        check("t5_wbdata", wd_RegWriteData_wb, 32'd0);
        check("t5_stall_after", {31'b0, wd_mem_stall}, 32'd0);

        issue(0, 0, 0, 0, 0, 0, 0, 0, st);
        issue(0, 0, 0, 0, 0, 0, 0, 0, st);
        issue(0, 0, 0, 0, 0, 0, 0, 0, st);
        check("end_wb_q", wb_q.size(), 32'd0);
        check("end_mem_q", mem_q.size(), 32'd0);
        check("end_main_err", {31'b0, mem_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
